mesi_coherence_monitor: RTL

- Synthesizable, parametrised coherence monitor placed beside mesi_isc.
- Keeps a shadow MESI table per CPU per tracked line, updated from per-CPU state-change reports.
- Checks the single-owner invariant on every updated line and checks each CPU's coherence-bus command/ack handshake against a timeout.
- Captures the first violation, counts all violation cycles, and exposes sticky error outputs for simulation and FPGA debug.

---
 rtl/mesi_mon_pkg.sv | 30 +++
 rtl/mesi_mon_ack_timer.sv | 45 ++++
 rtl/mesi_coherence_monitor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mesi_mon_pkg.sv
// Shared types and constants for the MESI coherence monitor.
package mesi_mon_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_state_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_MULTI_OWNER  = 2'd1,
        ERR_OWNER_SHARER = 2'd2,
        ERR_ACK_TIMEOUT  = 2'd3
    } err_type_e;

    typedef enum logic {
        CAP_IDLE,
        CAP_CAPTURED
    } cap_state_e;

    localparam int unsigned CBUS_NOP = 0;

    // M and E both grant exclusive ownership of a line.
    function automatic logic is_owner(mesi_state_e s);
        return (s == MESI_E) || (s == MESI_M);
    endfunction

endpackage

// File: rtl/mesi_mon_ack_timer.sv
// Per-CPU coherence-bus handshake timer: counts pending cycles, pulses once at timeout.
module mesi_mon_ack_timer
    import mesi_mon_pkg::*;
#(
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned ACK_TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd,
    input  logic                      cbus_ack,
    output logic                      timeout_pulse_o,
    output logic                      timeout_o
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          pending;

    // Pending detect, saturating count and the one-shot pulse on the edge the count reaches the limit.
    always_comb begin
        pending = (cbus_cmd != CBUS_CMD_WIDTH'(CBUS_NOP)) && !cbus_ack;
        cnt_d   = '0;
        if (pending) begin
            if (cnt_q == TW'(ACK_TIMEOUT)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        timeout_pulse_o = pending && (cnt_q == TW'(ACK_TIMEOUT - 1));
        timeout_o       = (cnt_q == TW'(ACK_TIMEOUT));
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mesi_coherence_monitor.sv
// Shadow MESI table, single-owner invariant check, ack timeouts and first-error capture.
module mesi_coherence_monitor
    import mesi_mon_pkg::*;
#(
    parameter int unsigned NUM_CPUS       = 4,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned LINE_W         = 4,
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned ACK_TIMEOUT    = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CPUS-1:0]                upd_vld,
    input  logic [NUM_CPUS*LINE_W-1:0]         upd_line,
    input  logic [NUM_CPUS*2-1:0]              upd_state,
    input  logic [NUM_CPUS*CBUS_CMD_WIDTH-1:0] cbus_cmd,
    input  logic [NUM_CPUS-1:0]                cbus_ack,
    input  logic                               err_clr,
    output logic                               err_o,
    output logic [1:0]                         err_type,
    output logic [LINE_W-1:0]                  err_line,
    output logic [NUM_CPUS-1:0]                err_cpu_mask,
    output logic [CNT_W-1:0]                   err_cnt,
    output logic [NUM_CPUS-1:0]                timeout_o
);

    mesi_state_e shadow_q [NUM_CPUS][NUM_LINES];
    mesi_state_e shadow_d [NUM_CPUS][NUM_LINES];
    logic [NUM_CPUS-1:0] chk_vld_q, chk_vld_d;
    logic [LINE_W-1:0]   chk_line_q [NUM_CPUS];
    logic [LINE_W-1:0]   chk_line_d [NUM_CPUS];

    logic [NUM_CPUS-1:0] line_mask [NUM_CPUS];
    logic [NUM_CPUS-1:0] multi_own, own_shr;
    logic [NUM_CPUS-1:0] tmo_pulse;

    err_type_e           sel_type;
    logic [LINE_W-1:0]   sel_line;
    logic [NUM_CPUS-1:0] sel_mask;
    logic                any_err;

    cap_state_e          state_q, state_d;
    logic                load_cap, clr_cap;
    err_type_e           err_type_q, err_type_d;
    logic [LINE_W-1:0]   err_line_q, err_line_d;
    logic [NUM_CPUS-1:0] err_mask_q, err_mask_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    // Stage 0: each CPU writes only its own column; remember which lines to check next cycle.
    always_comb begin
        shadow_d  = shadow_q;
        chk_vld_d = upd_vld;
        for (int unsigned c = 0; c < NUM_CPUS; c++) begin
            chk_line_d[c] = upd_line[c*LINE_W +: LINE_W];
            if (upd_vld[c]) begin
                shadow_d[c][upd_line[c*LINE_W +: LINE_W]] = mesi_state_e'(upd_state[c*2 +: 2]);
            end
        end
    end

    // Shadow table and check-stage pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NUM_CPUS; c++) begin
                for (int unsigned l = 0; l < NUM_LINES; l++) begin
                    shadow_q[c][l] <= MESI_I;
                end
                chk_line_q[c] <= '0;
            end
            chk_vld_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            chk_vld_q  <= chk_vld_d;
            chk_line_q <= chk_line_d;
        end
    end

    // Stage 1: classify each line updated last cycle against the post-update table.
    always_comb begin : line_check
        int unsigned n_own;
        int unsigned n_shr;
        for (int unsigned c = 0; c < NUM_CPUS; c++) begin
            n_own        = 0;
            n_shr        = 0;
            line_mask[c] = '0;
            for (int unsigned k = 0; k < NUM_CPUS; k++) begin
                if (is_owner(shadow_q[k][chk_line_q[c]])) begin
                    n_own = n_own + 1;
                end
                if (shadow_q[k][chk_line_q[c]] == MESI_S) begin
                    n_shr = n_shr + 1;
                end
                if (shadow_q[k][chk_line_q[c]] != MESI_I) begin
                    line_mask[c][k] = 1'b1;
                end
            end
            multi_own[c] = chk_vld_q[c] && (n_own > 1);
            own_shr[c]   = chk_vld_q[c] && (n_own == 1) && (n_shr > 0);
        end
    end

    // Per-CPU ack timers.
    for (genvar g = 0; g < NUM_CPUS; g++) begin : g_timer
        mesi_mon_ack_timer #(
            .CBUS_CMD_WIDTH (CBUS_CMD_WIDTH),
            .ACK_TIMEOUT    (ACK_TIMEOUT)
        ) u_timer (
            .clk             (clk),
            .rst             (rst),
            .cbus_cmd        (cbus_cmd[g*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH]),
            .cbus_ack        (cbus_ack[g]),
            .timeout_pulse_o (tmo_pulse[g]),
            .timeout_o       (timeout_o[g])
        );
    end

    // Error priority: type 1, then type 2, then type 3; lowest CPU index within a type.
    always_comb begin
        sel_type = ERR_NONE;
        sel_line = '0;
        sel_mask = '0;
        for (int unsigned c = 0; c < NUM_CPUS; c++) begin
            if (sel_type == ERR_NONE && multi_own[c]) begin
                sel_type = ERR_MULTI_OWNER;
                sel_line = chk_line_q[c];
                sel_mask = line_mask[c];
            end
        end
        for (int unsigned c = 0; c < NUM_CPUS; c++) begin
            if (sel_type == ERR_NONE && own_shr[c]) begin
                sel_type = ERR_OWNER_SHARER;
                sel_line = chk_line_q[c];
                sel_mask = line_mask[c];
            end
        end
        for (int unsigned c = 0; c < NUM_CPUS; c++) begin
            if (sel_type == ERR_NONE && tmo_pulse[c]) begin
                sel_type    = ERR_ACK_TIMEOUT;
                sel_line    = '0;
                sel_mask    = '0;
                sel_mask[c] = 1'b1;
            end
        end
        any_err = (sel_type != ERR_NONE);
    end

    // Capture FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture FSM next state: a new error wins over a simultaneous clear.
    always_comb begin
        state_d = state_q;
        if (any_err) begin
            state_d = CAP_CAPTURED;
        end else if (err_clr) begin
            state_d = CAP_IDLE;
        end
    end

    // Capture FSM outputs.
    always_comb begin
        load_cap = any_err && ((state_q == CAP_IDLE) || err_clr);
        clr_cap  = err_clr && !any_err;
        err_o    = (state_q == CAP_CAPTURED);
    end

    // Capture registers and saturating error-cycle counter (counter ignores err_clr).
    always_comb begin
        err_type_d = err_type_q;
        err_line_d = err_line_q;
        err_mask_d = err_mask_q;
        if (load_cap) begin
            err_type_d = sel_type;
            err_line_d = sel_line;
            err_mask_d = sel_mask;
        end else if (clr_cap) begin
            err_type_d = ERR_NONE;
            err_line_d = '0;
            err_mask_d = '0;
        end
        err_cnt_d = err_cnt_q;
        if (any_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Capture and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_type_q <= ERR_NONE;
            err_line_q <= '0;
            err_mask_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_type_q <= err_type_d;
            err_line_q <= err_line_d;
            err_mask_q <= err_mask_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_type     = err_type_q;
    assign err_line     = err_line_q;
    assign err_cpu_mask = err_mask_q;
    assign err_cnt      = err_cnt_q;

endmodule
